// File: rtl/shft_seq_ctrl.sv
// shft_seq_ctrl
// Sequencer for the 8-bit load/shift register (shft_mod).
// - Accepts bytes over a valid/ready handshake.
// - Keeps at most one byte pending while another byte is being shifted out.
// - Drives the register's load, dir and LD inputs.
// - Returns the register's cout to the user side as a framed serial stream.
//
// Optional feature:
// - Define SHFT_PARITY_EN to append one even-parity bit after the 8 data bits.
// - In that build, frame_done moves to the parity cycle.
//
// Parameter:
// - GAP_CYCLES (0..15) inserts idle cycles after every frame, before the next LOAD.

module shft_seq_ctrl #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_lsb,
    output logic       shft_load,
    output logic       shft_dir,
    output logic [7:0] shft_ld,
    input  logic       shft_cout,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       frame_done,
    output logic       busy
);

    // PAR only exists when the parity bit is configured in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
`ifdef SHFT_PARITY_EN
        PAR   = 3'd4,
`endif
        GAP   = 3'd3
    } state_t;

    // The gap counter runs 0..GAP_CYCLES-1.
    // When GAP_CYCLES is 0 the GAP state is never entered, so the terminal value is irrelevant.
    localparam int         GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [3:0] GAP_LAST     = GAP_LAST_INT[3:0];

    state_t     state;
    state_t     state_nxt;
    state_t     after_frame;

    logic       buf_full;
    logic [7:0] buf_data;
    logic       buf_lsb;
    logic       accept;

    logic       dir_reg;
    logic [2:0] bit_cnt;
    logic [3:0] gap_cnt;
`ifdef SHFT_PARITY_EN
    logic       par_reg;
`endif

    assign in_ready = !buf_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE) || buf_full;

    // Where a frame goes once its last bit has been sent:
    // - into the gap when one is configured,
    // - otherwise straight into the pending byte,
    // - otherwise back to idle.
    always_comb begin
        after_frame = IDLE;
        if (GAP_CYCLES > 0) begin
            after_frame = GAP;
        end else if (buf_full) begin
            after_frame = LOAD;
        end
    end

    // Next-state decode.
    // The registered outputs below are computed from it so that they line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_cnt == 3'd7) begin
`ifdef SHFT_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = after_frame;
`endif
                end
            end
`ifdef SHFT_PARITY_EN
            PAR: begin
                state_nxt = after_frame;
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = buf_full ? LOAD : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Single-entry input buffer.
    // - It is filled by a handshake.
    // - It is emptied by the cycle that hands its byte to the register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_full <= 1'b0;
            buf_data <= 8'h00;
            buf_lsb  <= 1'b0;
        end else if (state == LOAD) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= in_data;
            buf_lsb  <= in_lsb;
        end
    end

    // Controller state, bit/gap counters and registered datapath/user outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            dir_reg    <= 1'b0;
            bit_cnt    <= 3'd0;
            gap_cnt    <= 4'd0;
            shft_load  <= 1'b0;
            shft_dir   <= 1'b0;
            shft_ld    <= 8'h00;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SHFT_PARITY_EN
            par_reg    <= 1'b0;
`endif
        end else begin
            state <= state_nxt;

            // The frame direction is captured while the byte is being loaded.
            // It then stays fixed for every shift cycle of that frame.
            if (state == LOAD) begin
                dir_reg <= buf_lsb;
            end

            if (state == LOAD) begin
                bit_cnt <= 3'd0;
            end else if (state == SHIFT) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= 4'd0;
            end

`ifdef SHFT_PARITY_EN
            if (state == LOAD) begin
                par_reg <= ^buf_data;
            end
`endif

            shft_load <= (state_nxt == LOAD);
            shft_ld   <= (state_nxt == LOAD) ? buf_data : 8'h00;

            // The direction is presented together with the load so the register picks it up at once.
            // During shifting it follows the latched frame direction.
            if (state_nxt == LOAD) begin
                shft_dir <= buf_lsb;
            end else if (state_nxt == SHIFT) begin
                shft_dir <= (state == LOAD) ? buf_lsb : dir_reg;
            end

`ifdef SHFT_PARITY_EN
            ser_valid  <= (state_nxt == SHIFT) || (state_nxt == PAR);
            frame_done <= (state_nxt == PAR);
`else
            ser_valid  <= (state_nxt == SHIFT);
            frame_done <= (state == SHIFT) && (bit_cnt == 3'd6);
`endif
        end
    end

    // The serial bit passes cout straight through while a frame is live, so the data bit and ser_valid share a cycle.
    // Outside a frame the output is forced low.
    always_comb begin
        ser_bit = 1'b0;
        if (state == SHIFT) begin
            ser_bit = shft_cout;
        end
`ifdef SHFT_PARITY_EN
        else if (state == PAR) begin
            ser_bit = par_reg;
        end
`endif
    end

endmodule
